disk_ctrl: RTL and testbench

DISK_CTRL -- requirements
Module: disk_ctrl

---
 rtl/disk_pkg.sv | 24 ++
 rtl/disk_timeout.sv | 32 +++
 rtl/disk_ctrl.sv | 174 +++++++++++++++++
 tb/tb_disk_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/disk_pkg.sv
// Shared definitions for the disk controller: register map, STATUS/CMD bit
// positions and the command FSM state encoding.
package disk_pkg;

    localparam int REG_CMD    = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_LBA    = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;
    localparam int ST_REJ  = 3;

    localparam int CH_LSB  = 16;
    localparam int CMD_IE  = 30;
    localparam int CMD_DIR = 31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

endpackage

// File: rtl/disk_timeout.sv
// Cycle counter bounding how long an operation may wait for disk_done;
// expired is high in the cycle the count reaches TIMEOUT-1.
module disk_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/disk_ctrl.sv
// Multi-channel disk controller: bus slave with CMD/STATUS/LBA registers and
// per-channel sector buffer windows, issuing one disk operation at a time.
module disk_ctrl
    import disk_pkg::*;
#(
    parameter  int NCH     = 2,
    parameter  int BUF_AW  = 9,
    parameter  int TIMEOUT = 1024,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int AW      = BUF_AW + CHW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack,
    output logic              irq,
    output logic [NCH-1:0]    disk_rd_req,
    output logic [NCH-1:0]    disk_wr_req,
    input  logic [NCH-1:0]    disk_done,
    output logic [31:0]       disk_lba,
    output logic [CHW-1:0]    disk_sel,
    output logic [BUF_AW-1:0] disk_buf_addr,
    output logic              disk_buf_we,
    output logic [31:0]       disk_buf_wdata,
    input  logic [31:0]       disk_buf_rdata
);

    localparam int             OW    = BUF_AW + CHW;
    localparam logic [CHW:0]   NCH_V = (CHW + 1)'(NCH);

    state_e      state_q, state_d;
    logic [31:0] cmd_q, cmd_d, lba_q, lba_d, lba_out_q, lba_out_d, dat_o_q, dat_o_d;
    logic        done_q, done_d, err_q, err_d, rej_q, rej_d, ack_q, ack_d;
    logic        expired, issue;

    logic           acc, is_reg, busy, cmd_wr, lba_wr, st_wr, buf_acc, rej, cmd_ok;
    logic [OW-1:0]  reg_off;
    logic [CHW-1:0] bus_ch, act_ch, new_ch;
    logic [31:0]    status, rd_data;

    function automatic logic ch_bad(input logic [CHW-1:0] ch);
        return {1'b0, ch} >= NCH_V;
    endfunction

    // Decode: a transaction takes effect only in its first strobe cycle.
    always_comb begin
        acc     = stb & ~ack_q;
        is_reg  = addr[AW-1];
        reg_off = addr[OW-1:0];
        bus_ch  = addr[OW-1:BUF_AW];
        busy    = (state_q != S_IDLE);
        act_ch  = cmd_q[CH_LSB +: CHW];
        new_ch  = dat_i[CH_LSB +: CHW];
        cmd_wr  = acc & is_reg & we & (reg_off == OW'(REG_CMD));
        st_wr   = acc & is_reg & we & (reg_off == OW'(REG_STATUS));
        lba_wr  = acc & is_reg & we & (reg_off == OW'(REG_LBA));
        buf_acc = acc & ~is_reg;
        rej     = (cmd_wr & (busy | ch_bad(new_ch)))
                | (lba_wr & busy)
                | (buf_acc & (ch_bad(bus_ch) | (busy & (bus_ch == act_ch))));
        cmd_ok  = cmd_wr & ~rej;

        status                 = '0;
        status[ST_BUSY]        = busy;
        status[ST_DONE]        = done_q;
        status[ST_ERR]         = err_q;
        status[ST_REJ]         = rej_q;
        status[CH_LSB +: CHW]  = act_ch;

        rd_data = '0;
        if (!is_reg) begin
            rd_data = disk_buf_rdata;
        end else begin
            case (reg_off)
                OW'(REG_CMD):    rd_data = cmd_q;
                OW'(REG_STATUS): rd_data = status;
                OW'(REG_LBA):    rd_data = lba_q;
                default:         rd_data = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        lba_d     = lba_q;
        lba_out_d = lba_out_q;
        done_d    = done_q;
        err_d     = err_q;
        rej_d     = rej_q | rej;
        ack_d     = acc;
        dat_o_d   = (acc & ~we & ~rej) ? rd_data : '0;

        if (st_wr) begin
            done_d = done_q & ~dat_i[ST_DONE];
            err_d  = err_q  & ~dat_i[ST_ERR];
            rej_d  = rej_q  & ~dat_i[ST_REJ];
        end
        if (lba_wr && !rej)
            lba_d = dat_i;
        if (cmd_ok) begin
            cmd_d     = dat_i;
            lba_out_d = lba_q;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end

        // Completion on the selected channel beats a same-cycle timeout.
        case (state_q)
            S_IDLE:  if (cmd_ok) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (disk_done[act_ch]) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            lba_q     <= '0;
            lba_out_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rej_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_o_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            lba_q     <= lba_d;
            lba_out_q <= lba_out_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rej_q     <= rej_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
        end
    end

    disk_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != S_WAIT),
        .enable  (state_q == S_WAIT),
        .expired (expired)
    );

    // Combinational strobes are gated so reset aborts them in the same cycle.
    assign issue          = (state_q == S_ISSUE) & ~rst;
    assign disk_rd_req    = (issue & ~cmd_q[CMD_DIR]) ? (NCH'(1) << act_ch) : '0;
    assign disk_wr_req    = (issue &  cmd_q[CMD_DIR]) ? (NCH'(1) << act_ch) : '0;
    assign disk_buf_we    = buf_acc & we & ~rej & ~rst;
    assign disk_sel       = bus_ch;
    assign disk_buf_addr  = addr[BUF_AW-1:0];
    assign disk_buf_wdata = dat_i;
    assign disk_lba       = lba_out_q;
    assign ack            = ack_q;
    assign dat_o          = dat_o_q;
    assign irq            = (done_q | err_q) & cmd_q[CMD_IE];

endmodule

// File: tb/tb_disk_ctrl.sv
// Self-checking bench for disk_ctrl (NCH=2, BUF_AW=9, TIMEOUT=16): directed
// transactions against a cycle-timeline model of the controller.
module tb_disk_ctrl;

    localparam int NCH = 2, BUF_AW = 9, TIMEOUT = 16;

    logic        clk = 1'b0, rst = 1'b1, stb = 1'b0, we = 1'b0;
    logic [10:0] addr = '0;
    logic [31:0] dat_i = '0, dat_o, disk_lba, disk_buf_wdata, disk_buf_rdata;
    logic        ack, irq, disk_buf_we;
    logic [1:0]  disk_rd_req, disk_wr_req, disk_done = '0;
    logic [0:0]  disk_sel;
    logic [8:0]  disk_buf_addr;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    disk_ctrl #(.NCH(NCH), .BUF_AW(BUF_AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .dat_i(dat_i),
        .dat_o(dat_o), .ack(ack), .irq(irq), .disk_rd_req(disk_rd_req),
        .disk_wr_req(disk_wr_req), .disk_done(disk_done), .disk_lba(disk_lba),
        .disk_sel(disk_sel), .disk_buf_addr(disk_buf_addr), .disk_buf_we(disk_buf_we),
        .disk_buf_wdata(disk_buf_wdata), .disk_buf_rdata(disk_buf_rdata)
    );

    // Sector buffer environment behind the buffer port.
    assign disk_buf_rdata = mem[{disk_sel, disk_buf_addr}];
    always @(posedge clk) if (disk_buf_we) mem[{disk_sel, disk_buf_addr}] <= disk_buf_wdata;

    int checks = 0, fails = 0;

    // Model: timeline of the current operation plus the visible register state.
    int          cyc = 0, ack_cyc = -1, we_cyc = -1, done_cyc = -1, op_s = -100, op_ch = 0;
    bit          op_active = 0, op_dir = 0, m_done = 0, m_err = 0, m_rej = 0, chk_en = 0;
    logic [31:0] m_cmd = '0, m_lba_reg = '0, m_lba_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0] = op_active; s[1] = m_done; s[2] = m_err; s[3] = m_rej; s[16] = m_cmd[16];
        return s;
    endfunction

    function automatic logic [10:0] ra(input int off);
        return {1'b1, 10'(off)};
    endfunction

    function automatic logic [10:0] ba(input int ch, input int word);
        return {1'b0, 1'(ch), 9'(word)};
    endfunction

    // Advance one clock; outputs become stable #1 after the edge.
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        if (rst) begin
            op_active = 0; m_done = 0; m_err = 0; m_rej = 0;
            m_cmd = '0; m_lba_reg = '0; m_lba_out = '0;
            ack_cyc = -1; we_cyc = -1; done_cyc = -1;
        end else if (op_active && cyc == done_cyc) begin
            m_done = 1; op_active = 0;
        end else if (op_active && cyc == op_s + 2 + TIMEOUT) begin
            m_err = 1; op_active = 0;
        end
    endtask

    task automatic bus(input logic w, input logic [10:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        bit          rj;
        logic [31:0] exp;
        step();
        stb = 1'b1; we = w; addr = a; dat_i = d;
        rj = (a[10] && w && (a[9:0] == 0 || a[9:0] == 2) && op_active)
          || (!a[10] && op_active && a[9] == m_cmd[16]);
        exp = '0;
        if (!rj && !w) begin
            if (!a[10])                exp = mem[a[9:0]];
            else if (a[9:0] == 0)      exp = m_cmd;
            else if (a[9:0] == 1)      exp = m_status();
            else if (a[9:0] == 2)      exp = m_lba_reg;
        end
        ack_cyc = cyc + 1;
        if (!a[10] && w && !rj) we_cyc = cyc;
        step();
        stb = 1'b0; we = 1'b0;
        if (rj) m_rej = 1;
        else if (a[10] && w) begin
            if (a[9:0] == 0) begin
                m_cmd = d; m_lba_out = m_lba_reg; m_done = 0; m_err = 0;
                op_active = 1; op_s = cyc - 1; op_dir = d[31]; op_ch = int'(d[16]);
            end else if (a[9:0] == 1) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
                if (d[3]) m_rej = 0;
            end else if (a[9:0] == 2) m_lba_reg = d;
        end
        r = dat_o;
        if (!w) chk("dat_o", r, exp);
    endtask

    task automatic done_pulse(input int ch);
        step();
        disk_done = 2'(1 << ch);
        if (!rst && op_active && cyc >= op_s + 2 && ch == op_ch) done_cyc = cyc + 1;
        step();
        disk_done = '0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) if (chk_en) begin
        chk("ack", 32'(ack), 32'(cyc == ack_cyc));
        chk("buf_we", 32'(disk_buf_we), 32'(cyc == we_cyc));
        chk("rd_req", 32'(disk_rd_req),
            (op_active && !op_dir && cyc == op_s + 1 && !rst) ? 32'(1 << op_ch) : 32'd0);
        chk("wr_req", 32'(disk_wr_req),
            (op_active && op_dir && cyc == op_s + 1 && !rst) ? 32'(1 << op_ch) : 32'd0);
        chk("irq", 32'(irq), 32'((m_done | m_err) & m_cmd[30]));
        chk("disk_lba", disk_lba, m_lba_out);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1;

        // Reset state
        chk("rst_dat_o", dat_o, 32'h0);
        bus(0, ra(1), '0, r); chk("rst_status", r, 32'h0);
        bus(0, ra(0), '0, r); chk("rst_cmd", r, 32'h0);
        bus(0, ra(2), '0, r); chk("rst_lba", r, 32'h0);

        // Buffer write/read and unmapped register offsets
        bus(1, ba(0, 5), 32'hDEADBEEF, r);
        bus(1, ba(1, 5), 32'h12345678, r);
        bus(0, ba(0, 5), '0, r); chk("buf_rd_ch0", r, 32'hDEADBEEF);
        bus(0, ba(1, 5), '0, r); chk("buf_rd_ch1", r, 32'h12345678);
        bus(1, ra(5), 32'hFFFF_FFFF, r);
        bus(0, ra(3), '0, r); chk("unmapped_rd", r, 32'h0);

        // Read on channel 1, completion 5 cycles later
        bus(1, ra(2), 32'h10, r);
        bus(1, ra(0), 32'h0001_0000, r);
        chk("rd_req_pulse", 32'(disk_rd_req), 32'h2);
        chk("lba_latched", disk_lba, 32'h10);
        repeat (4) step();
        done_pulse(1);
        bus(0, ra(1), '0, r); chk("status_done", r, 32'h0001_0002);

        // Write on channel 0 with ie, no completion -> timeout
        bus(1, ra(0), 32'hC000_0000, r);
        chk("wr_req_pulse", 32'(disk_wr_req), 32'h1);
        n = 0;
        while (!irq && n < 40) begin step(); n++; end
        chk("timeout_latency", n, 17);
        chk("timeout_irq", 32'(irq), 32'h1);
        bus(0, ra(1), '0, r); chk("status_err", r, 32'h0000_0004);

        // Completion in the last counted cycle wins over timeout
        bus(1, ra(0), 32'h0000_0000, r);
        repeat (15) step();
        done_pulse(0);
        bus(0, ra(1), '0, r); chk("done_beats_timeout", r, 32'h0000_0002);

        // Busy rejections; done during ISSUE ignored
        bus(1, ra(0), 32'h0001_0000, r);
        disk_done = 2'b10;
        step();
        disk_done = '0;
        bus(1, ra(0), 32'h0000_0000, r);
        bus(0, ra(1), '0, r); chk("status_rej", r, 32'h0001_0009);
        bus(1, ra(1), 32'h8, r);
        bus(0, ra(1), '0, r); chk("status_rej_clr", r, 32'h0001_0001);
        bus(1, ra(2), 32'h99, r);
        bus(0, ra(2), '0, r); chk("lba_busy_kept", r, 32'h10);
        bus(0, ba(1, 5), '0, r); chk("buf_busy_rd", r, 32'h0);
        done_pulse(1);
        bus(0, ra(1), '0, r); chk("status_busy_end", r, 32'h0001_000A);
        bus(1, ra(1), 32'hE, r);
        bus(0, ra(1), '0, r); chk("status_w1c", r, 32'h0001_0000);

        // Wrong-channel done, then reset mid-WAIT
        bus(1, ra(0), 32'h4001_0000, r);
        repeat (2) step();
        done_pulse(0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_irq", 32'(irq), 32'h0);
        chk("abort_req", 32'({disk_rd_req, disk_wr_req}), 32'h0);
        chk("abort_dat_o", dat_o, 32'h0);
        chk("abort_lba", disk_lba, 32'h0);
        done_pulse(1);
        bus(0, ra(1), '0, r); chk("abort_status", r, 32'h0);
        bus(0, ra(0), '0, r); chk("abort_cmd", r, 32'h0);

        step();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
